// File: rtl/lane_matrix_multiplier.sv
// N x N matrix multiply / multiply-accumulate over internal register arrays.
// LANES MAC lanes produce one block of LANES adjacent Z columns per pass.
module lane_matrix_multiplier #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int IDX_W  = $clog2(N),
  parameter int ACC_W  = 2*DATA_W + $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              sat_en,
  input  logic              acc_mode,
  input  logic              a_we,
  input  logic [IDX_W-1:0]  a_i,
  input  logic [IDX_W-1:0]  a_j,
  input  logic [DATA_W-1:0] a_in,
  input  logic              b_we,
  input  logic [IDX_W-1:0]  b_i,
  input  logic [IDX_W-1:0]  b_j,
  input  logic [DATA_W-1:0] b_in,
  input  logic [IDX_W-1:0]  z_i,
  input  logic [IDX_W-1:0]  z_j,
  output logic [DATA_W-1:0] z_out,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  // state | meaning
  // IDLE  | waiting for start; host may write A and B
  // MAC   | N cycles of multiply-accumulate for the current row/column block
  // WB    | write lane results to Z, advance column block / row
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  localparam int NB   = N / LANES;
  localparam int CB_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ACC_W-1:0] ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] S_MAX = (ONE << (DATA_W-1)) - ONE;
  localparam logic signed [ACC_W-1:0] S_MIN = -(ONE << (DATA_W-1));
  localparam logic signed [ACC_W-1:0] U_MAX = (ONE << DATA_W) - ONE;
  localparam logic [DATA_W-1:0] D_SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] D_SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_mem [N][N];
  logic [DATA_W-1:0] b_mem [N][N];
  logic [DATA_W-1:0] z_mem [N][N];

  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] k;
  logic [CB_W-1:0]  colblk;
  logic             sm_q;
  logic             sat_q;
  logic             accm_q;

  logic signed [ACC_W-1:0] acc      [LANES];
  logic signed [ACC_W-1:0] mac_sum  [LANES];
  logic signed [ACC_W-1:0] b_ext    [LANES];
  logic signed [ACC_W-1:0] seed     [LANES];
  logic [IDX_W-1:0]        col_idx  [LANES];
  logic [DATA_W-1:0]       res      [LANES];
  logic [LANES-1:0]        lane_ovf;

  logic [DATA_W-1:0]       a_val;
  logic signed [ACC_W-1:0] a_ext;
  logic                    k_last;
  logic                    cb_last;
  logic                    row_last;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign z_out = z_mem[z_i][z_j];

  assign k_last   = (k == IDX_W'(N-1));
  assign cb_last  = (colblk == CB_W'(NB-1));
  assign row_last = (row == IDX_W'(N-1));

  always_comb begin
    a_val = a_mem[row][k];
    a_ext = ACC_W'($signed({sm_q & a_val[DATA_W-1], a_val}));
    for (int l = 0; l < LANES; l++) begin
      col_idx[l] = IDX_W'(int'(colblk) * LANES + l);
      b_ext[l]   = ACC_W'($signed({sm_q & b_mem[k][col_idx[l]][DATA_W-1], b_mem[k][col_idx[l]]}));
      seed[l]    = accm_q ? ACC_W'($signed({sm_q & z_mem[row][col_idx[l]][DATA_W-1],
                                            z_mem[row][col_idx[l]]}))
                          : '0;
      // First MAC cycle replaces the running sum with the seed.
      mac_sum[l] = ((k == '0) ? seed[l] : acc[l]) + a_ext * b_ext[l];
    end
  end

  // Out-of-range detection doubles as lossy-truncation detection: a value is
  // representable in DATA_W bits exactly when the dropped bits are pure extension.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic over;
      logic under;
      over        = sm_q ? (acc[l] > S_MAX) : (acc[l] > U_MAX);
      under       = sm_q ? (acc[l] < S_MIN) : acc[l][ACC_W-1];
      lane_ovf[l] = over | under;
      res[l]      = acc[l][DATA_W-1:0];
      if (sat_q && over)  res[l] = sm_q ? D_SMAX : '1;
      if (sat_q && under) res[l] = sm_q ? D_SMIN : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MAC;
      MAC:  if (k_last) state_nxt = WB;
      WB:   state_nxt = (cb_last && row_last) ? DONE : MAC;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A and B carry no reset; writes are accepted only in IDLE.
  always_ff @(posedge clk) begin
    if (a_we && state == IDLE) a_mem[a_i][a_j] <= a_in;
    if (b_we && state == IDLE) b_mem[b_i][b_j] <= b_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row    <= '0;
      k      <= '0;
      colblk <= '0;
      sm_q   <= 1'b0;
      sat_q  <= 1'b0;
      accm_q <= 1'b0;
      ovf    <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          z_mem[i][j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sm_q   <= signed_mode;
            sat_q  <= sat_en;
            accm_q <= acc_mode;
            ovf    <= 1'b0;
            row    <= '0;
            colblk <= '0;
            k      <= '0;
          end
        end
        MAC: begin
          for (int l = 0; l < LANES; l++) acc[l] <= mac_sum[l];
          k <= k_last ? '0 : k + IDX_W'(1);
        end
        WB: begin
          for (int l = 0; l < LANES; l++) z_mem[row][col_idx[l]] <= res[l];
          if (|lane_ovf) ovf <= 1'b1;
          if (cb_last) begin
            colblk <= '0;
            row    <= row_last ? '0 : row + IDX_W'(1);
          end else begin
            colblk <= colblk + CB_W'(1);
          end
          k <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_matrix_multiplier.sv
// Directed bench for lane_matrix_multiplier at default parameters (4x4, 32-bit, 2 lanes).
module tb_lane_matrix_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, signed_mode = 1'b0, sat_en = 1'b0, acc_mode = 1'b0;
  logic        a_we = 1'b0, b_we = 1'b0;
  logic [1:0]  a_i = '0, a_j = '0, b_i = '0, b_j = '0, z_i = '0, z_j = '0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [31:0] z_out;
  logic        busy, done, ovf;

  int errors = 0;
  int checks = 0;
  logic [31:0] ez [4][4];

  always #5 clk = ~clk;

  lane_matrix_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .sat_en(sat_en), .acc_mode(acc_mode),
    .a_we(a_we), .a_i(a_i), .a_j(a_j), .a_in(a_in),
    .b_we(b_we), .b_i(b_i), .b_j(b_j), .b_in(b_in),
    .z_i(z_i), .z_j(z_j), .z_out(z_out),
    .busy(busy), .done(done), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int i, input int j, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a_we = 1'b1; a_i = 2'(i); a_j = 2'(j); a_in = av;
    b_we = 1'b1; b_i = 2'(i); b_j = 2'(j); b_in = bv;
    @(negedge clk);
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic check_z(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        z_i = 2'(i); z_j = 2'(j);
        #1;
        chk($sformatf("%s_z%0d%0d", tag, i, j), z_out, ez[i][j]);
      end
  endtask

  // Start is driven during cycle 0; cycle c is sampled at the falling edge inside it.
  task automatic run_op(input logic sm, input logic sat, input logic acm,
                        input bit inject, input string tag);
    int first_done, ndone, bad_busy;
    first_done = -1; ndone = 0; bad_busy = 0;
    @(negedge clk);
    signed_mode = sm; sat_en = sat; acc_mode = acm; start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      start = 1'b0; a_we = 1'b0;
      if (inject && c == 5) begin
        a_we = 1'b1; a_i = 2'd0; a_j = 2'd0; a_in = 32'd99; start = 1'b1;
      end
      if (busy !== (c <= 41)) bad_busy++;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
    end
    signed_mode = 1'b0; sat_en = 1'b0; acc_mode = 1'b0;
    chk({tag, "_busy_window_errs"}, 32'(bad_busy), 32'd0);
    chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, "_done_cycle"}, 32'(first_done), 32'd41);
  endtask

  task automatic load_identity();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(i, j, (i == j) ? 32'd1 : 32'd0, 32'(4*i + j + 1));
        ez[i][j] = 32'(4*i + j + 1);
      end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ez[i][j] = 32'd0;
    check_z("rst");
    @(negedge clk) rst = 1'b1;

    load_identity();
    run_op(1'b0, 1'b0, 1'b0, 1'b0, "ident");
    check_z("ident");
    chk("ident_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ez[i][j] = 32'(2 * (4*i + j + 1));
    run_op(1'b0, 1'b0, 1'b1, 1'b0, "accum");
    check_z("accum");
    chk("accum_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ez[i][j] = 32'(4*i + j + 1);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, "protect");
    check_z("protect");
    run_op(1'b0, 1'b0, 1'b0, 1'b0, "protect_rerun");
    check_z("protect_rerun");

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(i, j, 32'hFFFF_FFFF, 32'd2);
        ez[i][j] = 32'hFFFF_FFF8;
      end
    run_op(1'b1, 1'b0, 1'b0, 1'b0, "signed");
    check_z("signed");
    chk("signed_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(i, j, 32'd0, 32'd0);
        ez[i][j] = 32'd0;
      end
    wr(0, 0, 32'h7FFF_FFFF, 32'd2);
    ez[0][0] = 32'h7FFF_FFFF;
    run_op(1'b1, 1'b1, 1'b0, 1'b0, "sat_pos");
    check_z("sat_pos");
    chk("sat_pos_ovf", 32'(ovf), 32'd1);

    ez[0][0] = 32'hFFFF_FFFE;
    run_op(1'b1, 1'b0, 1'b0, 1'b0, "trunc");
    check_z("trunc");
    chk("trunc_ovf", 32'(ovf), 32'd1);

    wr(0, 0, 32'hFFFF_FFFF, 32'd2);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, "sat_uns");
    z_i = 2'd0; z_j = 2'd0; #1;
    chk("sat_uns_z00", z_out, 32'hFFFF_FFFF);
    chk("sat_uns_ovf", 32'(ovf), 32'd1);

    wr(0, 0, 32'h8000_0000, 32'd2);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, "sat_neg");
    z_i = 2'd0; z_j = 2'd0; #1;
    chk("sat_neg_z00", z_out, 32'h8000_0000);
    chk("sat_neg_ovf", 32'(ovf), 32'd1);

    wr(0, 0, 32'd1, 32'd2);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, "clean");
    z_i = 2'd0; z_j = 2'd0; #1;
    chk("clean_z00", z_out, 32'd2);
    chk("clean_ovf", 32'(ovf), 32'd0);

    load_identity();
    run_op(1'b0, 1'b0, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midop_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("midop_rst_busy", 32'(busy), 32'd0);
    chk("midop_rst_done", 32'(done), 32'd0);
    chk("midop_rst_ovf",  32'(ovf),  32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ez[i][j] = 32'd0;
    check_z("midop_rst");
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ez[i][j] = 32'(4*i + j + 1);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
    check_z("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_matrix_multiplier.md
Name: lane_matrix_multiplier

Overview:
- Computes Z = A x B, or Z = Z + A x B, for square N x N matrices held in internal register arrays.
- Successor to the one-shot parallel multiplier. Adds a parametrised data width and lane count, signed/unsigned mode, optional saturation, an accumulate mode, a sticky overflow flag, and fully synchronous load ports.
- A host loads A and B through write ports, pulses start, waits for done, then reads Z through a combinational read port.

Parameters:
- N, 4, matrix dimension; N >= 2.
- DATA_W, 32, element width of A, B and Z.
- LANES, 2, parallel MAC lanes; must divide N.
- IDX_W, $clog2(N), row/column index width.
- ACC_W, 2*DATA_W+$clog2(N)+1, accumulator width per lane.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands/result, 0 = unsigned; sampled with start.
- sat_en  in  1  1 = clamp result to DATA_W range, 0 = keep low DATA_W bits; sampled with start.
- acc_mode  in  1  1 = accumulator seeded with existing Z element, 0 = seeded with zero; sampled with start.
- a_we  in  1  synchronous write enable for A.
- a_i, a_j  in  IDX_W each  A write row/column.
- a_in  in  DATA_W  A write data.
- b_we, b_i, b_j, b_in  in  1/IDX_W/IDX_W/DATA_W  same for B.
- z_i, z_j  in  IDX_W each  Z read address.
- z_out  out  DATA_W  Z[z_i][z_j], combinational.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse on completion.
- ovf  out  1  sticky; set if any element clamped or truncated with loss in the last operation.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; busy=0, done=0, ovf=0; all Z elements=0; counters=0. A and B are not reset.
- Reset mid-operation aborts immediately. Z is zeroed, so a partial result is never visible after reset.
- FSM states: IDLE, MAC, WB, DONE.
- IDLE:
  - start=1 latches signed_mode, sat_en and acc_mode.
  - Clears ovf, sets row=0, colblk=0, k=0, and goes to MAC.
- MAC, N cycles, k = 0..N-1: lane l (0..LANES-1) does acc[l] += A[row][k] * B[k][colblk*LANES+l].
  - Products use full 2*DATA_W width, sign- or zero-extended per signed_mode.
  - At k=0 the accumulator is seeded with the extended Z[row][col] if acc_mode=1, else 0.
  - At k=N-1, go to WB.
- WB, 1 cycle: each lane writes its result to Z[row][colblk*LANES+l].
  - sat_en=1: a value outside the DATA_W range (signed: -2^(DATA_W-1)..2^(DATA_W-1)-1; unsigned: 0..2^DATA_W-1) is clamped to the nearest bound and sets ovf.
  - sat_en=0: the low DATA_W bits are written; ovf is set if the discarded bits are not a pure sign/zero extension.
  - Then advance colblk; on wrap to 0 advance row.
  - If row and colblk both wrap, go to DONE; else go to MAC with k=0.
- DONE, 1 cycle: done=1, busy=0 on the following cycle, return to IDLE.
- Latency:
  - P = N*N/LANES passes.
  - With start accepted at cycle 0, MAC begins at cycle 1 and done is high at cycle 1 + P*(N+1).
  - Defaults: done at cycle 41.
- Busy window: busy=1 in MAC, WB and DONE.
- Writes during busy:
  - a_we and b_we are ignored while busy=1; A and B are unchanged.
  - Writes in IDLE take effect at the clock edge; a write in the same cycle as start is applied.
- start while busy is ignored; no re-arm.
- z_out always reflects the current Z array. Mid-operation reads may mix old and new elements.
- Simultaneous a_we and b_we in IDLE: both are performed.

Test Plan:
- Identity (defaults, unsigned): A=I, B[i][j]=4*i+j+1, start -> done exactly 41 cycles after the start cycle; Z==B; ovf=0; busy high for cycles 1..41 only.
- Signed: A all 0xFFFFFFFF, B all 2, signed_mode=1 -> every Z element = 0xFFFFFFF8 (-8); ovf=0.
- Saturation: A[0][0]=0x7FFFFFFF, B[0][0]=2, all other elements 0, signed_mode=1, sat_en=1 -> Z[0][0]=0x7FFFFFFF, ovf=1. Repeat with sat_en=0 -> Z[0][0]=0xFFFFFFFE, ovf=1. Next clean run -> ovf=0.
- Accumulate: identity run as in scenario 1, then a second start with acc_mode=1 -> Z[i][j] = 2*(4*i+j+1).
- Protection: during busy, write a_we to A[0][0]=99 and pulse start -> A[0][0] unchanged, single done pulse, result unaffected.
- Reset mid-op: drive rst=0 at cycle 20 -> busy=0, done=0, ovf=0 and z_out=0 for every address. A fresh start then completes correctly in 41 cycles.
